// File: rtl/em_sched_pkg.sv
// Shared types for the energy-monitor job scheduler.
// Build option: EM_SCHED_BEST_TRACK_EN enables best-energy tracking in em_scheduler.
package em_sched_pkg;

    typedef enum logic [2:0] {
        CFG    = 3'd0,
        IDLE   = 3'd1,
        SPIN   = 3'd2,
        STREAM = 3'd3,
        WAIT_E = 3'd4,
        RESULT = 3'd5
    } em_state_e;

    localparam int EM_DEF_DATAJ = 256 * 4;
    localparam int EM_DEF_BITH  = 4;

    // Row word as returned by the weight memory: {weight row, hbias}.
    typedef struct packed {
        logic [EM_DEF_DATAJ-1:0]       weight;
        logic signed [EM_DEF_BITH-1:0] hbias;
    } em_row_t;

    function automatic int em_fifo_depth(input int mem_lat);
        return mem_lat + 1;
    endfunction

endpackage

// File: rtl/em_sched_row_fifo.sv
// Small synchronous FIFO for returned weight rows; head is read combinationally.
module em_sched_row_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/em_scheduler.sv
// Job scheduler feeding spins and streamed weight rows to an energy monitor.
// Build option: EM_SCHED_BEST_TRACK_EN adds a best-energy register driving res_best_o.
module em_scheduler
    import em_sched_pkg::*;
#(
    parameter int DATASPIN         = 256,
    parameter int BITJ             = 4,
    parameter int BITH             = 4,
    parameter int SCALING_BIT      = 5,
    parameter int ENERGY_TOTAL_BIT = 32,
    parameter int MEM_LAT          = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                job_valid_i,
    output logic                                job_ready_o,
    input  logic [DATASPIN-1:0]                 job_spin_i,
    input  logic [SCALING_BIT-1:0]              job_hscaling_i,
    output logic                                mem_req_o,
    output logic [$clog2(DATASPIN)-1:0]         mem_addr_o,
    input  logic [DATASPIN*BITJ+BITH-1:0]       mem_rdata_i,
    output logic                                cfg_valid_o,
    input  logic                                cfg_ready_i,
    output logic [$clog2(DATASPIN)-1:0]         cfg_counter_o,
    output logic                                spin_valid_o,
    input  logic                                spin_ready_i,
    output logic [DATASPIN-1:0]                 spin_o,
    output logic                                weight_valid_o,
    input  logic                                weight_ready_i,
    output logic [DATASPIN*BITJ-1:0]            weight_o,
    output logic signed [BITH-1:0]              hbias_o,
    output logic [SCALING_BIT-1:0]              hscaling_o,
    input  logic                                energy_valid_i,
    output logic                                energy_ready_o,
    input  logic signed [ENERGY_TOTAL_BIT-1:0]  energy_i,
    output logic                                res_valid_o,
    input  logic                                res_ready_i,
    output logic signed [ENERGY_TOTAL_BIT-1:0]  res_energy_o,
    output logic                                res_best_o,
    output logic                                busy_o
);
    localparam int DATAJ = DATASPIN * BITJ;
    localparam int AW    = $clog2(DATASPIN);
    localparam int DEPTH = em_fifo_depth(MEM_LAT);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int EW    = ENERGY_TOTAL_BIT;

    typedef struct packed {
        logic [DATAJ-1:0]       weight;
        logic signed [BITH-1:0] hbias;
    } row_t;

    em_state_e               state;
    logic [DATASPIN-1:0]     spin_q;
    logic [SCALING_BIT-1:0]  hscaling_q;
    logic signed [EW-1:0]    energy_q;
    logic [AW:0]             issue_cnt, xfer_cnt;
    logic [MEM_LAT:1]        vld_pipe;
    logic [CW-1:0]           outstanding, fifo_cnt;
    logic                    fifo_full, fifo_empty, pop, issue_ok;
    row_t                    head;

    always_comb begin
        outstanding = '0;
        for (int i = 1; i <= MEM_LAT; i++) outstanding = outstanding + CW'(vld_pipe[i]);
    end

    // The row popped this cycle frees its slot in time for a read issued now,
    // which keeps one row per cycle flowing while never overrunning the FIFO.
    assign pop      = weight_valid_o && weight_ready_i;
    assign issue_ok = (int'(outstanding) + int'(fifo_cnt) - int'(pop)) < DEPTH;

    assign mem_req_o  = (state == STREAM) && (issue_cnt < (AW+1)'(DATASPIN)) && issue_ok;
    assign mem_addr_o = issue_cnt[AW-1:0];

    // Clearing the read tracker on reset drops any data still returning from memory.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= mem_req_o;
            for (int i = 2; i <= MEM_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    em_sched_row_fifo #(.DEPTH(DEPTH), .WIDTH(DATAJ + BITH)) u_row_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (vld_pipe[MEM_LAT] && !fifo_full),
        .wdata (mem_rdata_i),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= CFG;
            spin_q     <= '0;
            hscaling_q <= '0;
            energy_q   <= '0;
            issue_cnt  <= '0;
            xfer_cnt   <= '0;
        end else begin
            case (state)
                CFG:    if (cfg_ready_i) state <= IDLE;
                IDLE:   if (job_valid_i) begin
                            spin_q     <= job_spin_i;
                            hscaling_q <= job_hscaling_i;
                            state      <= SPIN;
                        end
                SPIN:   if (spin_ready_i) begin
                            issue_cnt <= '0;
                            xfer_cnt  <= '0;
                            state     <= STREAM;
                        end
                STREAM: begin
                            if (mem_req_o) issue_cnt <= issue_cnt + (AW+1)'(1);
                            if (pop) begin
                                xfer_cnt <= xfer_cnt + (AW+1)'(1);
                                if (xfer_cnt == (AW+1)'(DATASPIN - 1)) state <= WAIT_E;
                            end
                        end
                WAIT_E: if (energy_valid_i) begin
                            energy_q <= energy_i;
                            state    <= RESULT;
                        end
                RESULT: if (res_ready_i) state <= IDLE;
                default: state <= CFG;
            endcase
        end
    end

    // CFG is the reset state, so its valid is masked while reset is held.
    assign cfg_valid_o    = (state == CFG) && !rst_i;
    assign cfg_counter_o  = cfg_valid_o ? AW'(DATASPIN - 1) : '0;
    assign job_ready_o    = (state == IDLE);
    assign spin_valid_o   = (state == SPIN);
    assign spin_o         = spin_q;
    assign weight_valid_o = !fifo_empty;
    assign weight_o       = head.weight;
    assign hbias_o        = head.hbias;
    assign hscaling_o     = hscaling_q;
    assign energy_ready_o = (state == WAIT_E);
    assign res_valid_o    = (state == RESULT);
    assign res_energy_o   = energy_q;
    assign busy_o         = (state != IDLE);

`ifdef EM_SCHED_BEST_TRACK_EN
    logic signed [EW-1:0] best_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                          best_q <= {1'b0, {(EW-1){1'b1}}};
        else if (res_valid_o && res_ready_i && res_best_o)  best_q <= energy_q;
    end

    assign res_best_o = res_valid_o && (energy_q < best_q);
`else
    assign res_best_o = 1'b0;
`endif

endmodule

// File: doc/em_scheduler.md
EM_SCHEDULER -- requirements
Module: em_scheduler

Interface
REQ-001 SHALL have parameter DATASPIN, default 256: spins per vector and weight rows per job.
REQ-002 SHALL have parameter BITJ, default 4: bits per J element; DATAJ = DATASPIN*BITJ.
REQ-003 SHALL have parameters BITH=4, SCALING_BIT=5, ENERGY_TOTAL_BIT=32, MEM_LAT=1: bias width, scaling width, energy width, weight-memory read latency (1..4).
REQ-004 SHALL have port clk_i, input, 1: single clock; one clock, reset asynchronous active-high.
REQ-005 SHALL have port rst_i, input, 1: asynchronous active-high reset.
REQ-006 SHALL have job_valid_i/job_ready_o, in/out, 1 each; job_spin_i, in, DATASPIN; job_hscaling_i, in, SCALING_BIT: job request.
REQ-007 SHALL have mem_req_o, out, 1; mem_addr_o, out, $clog2(DATASPIN); mem_rdata_i, in, DATAJ+BITH ({row, hbias}): weight memory, data valid exactly MEM_LAT cycles after mem_req_o.
REQ-008 SHALL have cfg_valid_o/cfg_ready_i, cfg_counter_o ($clog2(DATASPIN)): monitor config channel.
REQ-009 SHALL have spin_valid_o/spin_ready_i, spin_o (DATASPIN): monitor spin channel.
REQ-010 SHALL have weight_valid_o/weight_ready_i, weight_o (DATAJ), hbias_o (BITH, signed), hscaling_o (SCALING_BIT): monitor weight channel.
REQ-011 SHALL have energy_valid_i/energy_ready_o, energy_i (ENERGY_TOTAL_BIT, signed): monitor result.
REQ-012 SHALL have res_valid_o/res_ready_i, res_energy_o (ENERGY_TOTAL_BIT, signed), res_best_o (1), busy_o (1): job result and status.

Function
REQ-013 All channels SHALL be valid/ready; transfer on valid&&ready; asserted valid and its data SHALL hold until transfer.
REQ-014 FSM states SHALL be CFG, IDLE, SPIN, STREAM, WAIT_E, RESULT; CFG entered only after reset.
REQ-015 CFG: cfg_valid_o=1, cfg_counter_o=DATASPIN-1; on transfer -> IDLE.
REQ-016 IDLE: job_ready_o=1; on job transfer capture spin, hscaling, -> SPIN.
REQ-017 SPIN: spin_valid_o=1, spin_o=captured spin; on transfer -> STREAM, row counter=0.
REQ-018 STREAM: issue mem_req_o with mem_addr_o=row counter, increment per issue, only when outstanding reads + buffered rows < MEM_LAT+1.
REQ-019 Returned rows SHALL enter a (MEM_LAT+1)-entry FIFO; head drives weight_o/hbias_o; hscaling_o=captured value; weight_valid_o=FIFO non-empty.
REQ-020 Rows SHALL reach the monitor in address order 0..DATASPIN-1 with no loss/duplication under any weight_ready_i pattern.
REQ-021 After DATASPIN weight transfers -> WAIT_E; energy_ready_o=1 only in WAIT_E; on transfer latch energy_i -> RESULT.
REQ-022 RESULT: res_valid_o=1 with latched energy; on transfer -> IDLE.
REQ-023 With weight_ready_i held high and MEM_LAT=1, steady-state throughput SHALL be one row per cycle.
REQ-024 busy_o SHALL be 1 in every state except IDLE.
REQ-025 Energy arriving outside WAIT_E SHALL be ignored (energy_ready_o=0).

Reset
REQ-026 On rst_i: state=CFG, FIFO empty, outstanding=0, row counter=0, all valid/req outputs 0, job_ready_o=0, energy_ready_o=0, data outputs 0, best register = most-positive value.
REQ-027 Reset mid-job SHALL abandon the job; memory data returning after reset SHALL be discarded.

Configuration
REQ-028 With EM_SCHED_BEST_TRACK_EN defined: res_best_o=1 iff latched energy < best register; best updated on that RESULT transfer.
REQ-029 Without EM_SCHED_BEST_TRACK_EN: no best register, res_best_o tied 0.

Structure
REQ-030 Shared package em_sched_pkg SHALL hold the state enum and row-word struct {weight, hbias}.
REQ-031 FIFO SHALL be sub-module em_sched_row_fifo (parameterised depth/width, push/pop, full/empty).

Verification
REQ-032 Reset release, cfg_ready_i=1 -> one cfg transfer with cfg_counter_o=DATASPIN-1, then job_ready_o=1.
REQ-033 DATASPIN=4, MEM_LAT=1, all ready high -> addresses 0,1,2,3 on consecutive cycles, 4 weight transfers in 4 consecutive cycles.
REQ-034 weight_ready_i toggling 1/0, MEM_LAT=3 -> rows 0..DATASPIN-1 in order, never >4 rows in flight+buffered.
REQ-035 Energies -5, 3, -9 over three jobs (BEST_TRACK_EN) -> res_best_o 1, 0, 1; res_energy_o -5, 3, -9.
REQ-036 rst_i pulsed during STREAM row 2 -> all valids 0 next cycle, CFG re-entered, late mem data not forwarded.
